// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition path (sequencer, waveform buffer, serializer).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acq_pkg;

    // Sequencer state encoding; values are visible on state_dbg.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READOUT = 3'd3,
        ST_HOLDOFF = 3'd4
    } acq_state_t;

    // Frame geometry shared with the buffer and the UART serializer.
    localparam int ACQ_NUM_SAMPLES = 500;
    localparam int ACQ_SAMPLE_W    = 14;
    localparam int ACQ_ADDR_W      = 9;

endpackage

// File: rtl/acq_readout_sequencer_threshold_trigger.sv
// Registers the live ADC stream and flags a rising crossing of trig_level.
// Latency: sample_q is adc_sample delayed 1 clk; trig is combinational on the current sample.
// Backpressure: none; a sample arrives every clk and is always accepted.
//
// Ports: clk, reset_n (async, active low); adc_sample, trig_level in;
//        trig (rising-crossing pulse), sample_q (registered sample) out.
module threshold_trigger
    import acq_pkg::*;
#(
    parameter int SAMPLE_W = ACQ_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] adc_sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    output logic                trig,
    output logic [SAMPLE_W-1:0] sample_q
);

    // prev_sample resets to all-ones so the first sample after reset can
    // never look like a rising crossing.
    logic [SAMPLE_W-1:0] prev_sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample <= '1;
            sample_q    <= '0;
        end else begin
            prev_sample <= adc_sample;
            sample_q    <= adc_sample;
        end
    end

    assign trig = (prev_sample < trig_level) && (adc_sample >= trig_level);

endmodule

// File: rtl/acq_readout_sequencer.sv
// Sequences arm -> trigger -> capture NUM_SAMPLES -> UART readout -> holdoff.
// Latency: first buffer write 1 clk after the triggering sample; acquire drops 1 clk after the last write.
// Backpressure: none on the sample stream; readout waits on tx_done, bounded by TX_TIMEOUT.
//
// Ports: clk, reset_n (async, active low); run, continuous, adc_sample, trig_level,
//        tx_done in; acquire, wr_en/wr_addr/wr_data (buffer write), busy,
//        frame_count, timeout_err (sticky), state_dbg out.
module acq_readout_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_SAMPLES    = ACQ_NUM_SAMPLES,
    parameter int SAMPLE_W       = ACQ_SAMPLE_W,
    parameter int ADDR_W         = ACQ_ADDR_W,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int TX_TIMEOUT     = 2**24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                continuous,
    input  logic [SAMPLE_W-1:0] adc_sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                tx_done,
    output logic                acquire,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                busy,
    output logic [15:0]         frame_count,
    output logic                timeout_err,
    output logic [2:0]          state_dbg
);

    // One timer serves both READOUT and HOLDOFF; size it for the longer one.
    localparam int TMR_MAX = (TX_TIMEOUT > HOLDOFF_CYCLES) ? TX_TIMEOUT : HOLDOFF_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    acq_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             trig;

    threshold_trigger #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_sample (adc_sample),
        .trig_level (trig_level),
        .trig       (trig),
        .sample_q   (wr_data)
    );

    // wr_addr doubles as the capture sample counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            acquire     <= 1'b1;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            timer       <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acquire <= 1'b1;
                    wr_en   <= 1'b0;
                    if (run) begin
                        state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    acquire <= 1'b1;
                    wr_en   <= 1'b0;
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (trig) begin
                        // The triggering sample lands in wr_data on this
                        // same edge, so it becomes write 0 next cycle.
                        state   <= ST_CAPTURE;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                    end
                end

                ST_CAPTURE: begin
                    // run is deliberately ignored: a started frame always completes.
                    if (wr_addr == ADDR_W'(NUM_SAMPLES - 1)) begin
                        state   <= ST_READOUT;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        acquire <= 1'b0;
                        timer   <= '0;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end

                ST_READOUT: begin
                    // tx_done is tested first so it wins over a coincident timeout.
                    if (tx_done) begin
                        state       <= ST_HOLDOFF;
                        acquire     <= 1'b1;
                        timer       <= '0;
                        frame_count <= frame_count + 16'd1;
                    end else if (timer == TMR_W'(TX_TIMEOUT - 1)) begin
                        state       <= ST_HOLDOFF;
                        acquire     <= 1'b1;
                        timer       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_HOLDOFF: begin
                    // acquire stays high for the whole holdoff to reset the serializer.
                    acquire <= 1'b1;
                    if (timer == TMR_W'(HOLDOFF_CYCLES - 1)) begin
                        timer <= '0;
                        state <= (run && continuous) ? ST_ARMED : ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    acquire <= 1'b1;
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    timer   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Self-checking bench for acq_readout_sequencer (TX_TIMEOUT shortened to 100).
// Latency: n/a.
// Backpressure: n/a.
module tb_acq_readout_sequencer;

    localparam int NS  = 500;
    localparam int HO  = 1024;
    localparam int TMO = 100;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_READOUT = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        continuous;
    logic [13:0] adc_sample;
    logic [13:0] trig_level;
    logic        tx_done;
    logic        acquire;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [13:0] wr_data;
    logic        busy;
    logic [15:0] frame_count;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    acq_readout_sequencer #(
        .TX_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .continuous  (continuous),
        .adc_sample  (adc_sample),
        .trig_level  (trig_level),
        .tx_done     (tx_done),
        .acquire     (acquire),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_count (frame_count),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   writes_seen = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: every buffer write must match the head of the scoreboard,
    // writes must be back-to-back, and the cycle after address NS-1 must be
    // the first READOUT cycle with acquire low.
    logic prev_wr_en = 1'b0;
    logic after_last = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (after_last) begin
            after_last = 1'b0;
            check("wr_en_after_last", wr_en, 0);
            check("acquire_after_last", acquire, 0);
            check("state_after_last", state_dbg, S_READOUT);
        end
        if (wr_en) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                if (e.addr != 0) check("write_contiguous", prev_wr_en, 1);
            end
            if (wr_addr == 9'(NS - 1)) after_last = 1'b1;
        end
        prev_wr_en = wr_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            step();
            n++;
        end
        check("reach_state", state_dbg, s);
    endtask

    // Drive pre (below level) then base (at/above level); expected data is
    // the ramp base, base+1, ... written to addresses 0.. in order.
    task automatic capture(input int pre, input int base, input int abort_at);
        wait_state(S_ARMED, 3000);
        adc_sample = 14'(pre);
        step();
        adc_sample = 14'(base);
        for (int i = 0; i < NS; i++) exp_q.push_back('{addr: i, data: base + i});
        for (int j = 1; j <= NS; j++) begin
            step();
            if (j == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_wr_en", wr_en, 0);
                check("abort_acquire", acquire, 1);
                check("abort_state", state_dbg, S_IDLE);
                check("abort_frame_count", frame_count, 0);
                check("abort_timeout_err", timeout_err, 0);
                check("abort_busy", busy, 0);
                exp_q.delete();
                step();
                step();
                reset_n = 1'b1;
                return;
            end
            if (j < NS) adc_sample = 14'(base + j);
        end
    endtask

    // done_at = READOUT cycle (1-based) with tx_done high; 0 = never.
    task automatic do_readout(input int done_at, input int exp_frames, input logic exp_err);
        int c = 0;
        wait_state(S_READOUT, 10);
        check("readout_acquire", acquire, 0);
        while (state_dbg === S_READOUT && c < TMO + 10) begin
            c++;
            tx_done = (c == done_at);
            step();
        end
        tx_done = 1'b0;
        check("readout_len", c, (done_at > 0 && done_at <= TMO) ? done_at : TMO);
        check("frame_count", frame_count, exp_frames);
        check("timeout_err", timeout_err, exp_err);
    endtask

    task automatic do_holdoff(input logic inject, input logic [2:0] next_s);
        int c  = 0;
        int w0 = writes_seen;
        check("holdoff_state", state_dbg, S_HOLDOFF);
        check("holdoff_acquire", acquire, 1);
        while (state_dbg === S_HOLDOFF && c < HO + 10) begin
            c++;
            if (inject && c == 500) adc_sample = 14'd7000;
            if (inject && c == 501) adc_sample = 14'd8500;
            step();
        end
        check("holdoff_len", c, HO);
        check("holdoff_exit", state_dbg, next_s);
        check("holdoff_no_write", writes_seen - w0, 0);
    endtask

    initial begin
        int w0;
        reset_n    = 1'b0;
        run        = 1'b0;
        continuous = 1'b0;
        adc_sample = 14'd9000;
        trig_level = 14'd8000;
        tx_done    = 1'b0;
        step();
        step();
        check("rst_state", state_dbg, S_IDLE);
        check("rst_acquire", acquire, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Sample held above level from the first post-reset cycle: no trigger.
        reset_n = 1'b1;
        run     = 1'b1;
        repeat (20) step();
        check("stationary_state", state_dbg, S_ARMED);
        check("stationary_busy", busy, 1);
        check("stationary_no_write", writes_seen, 0);

        // Frame 1: 9000 -> 7999 -> 8000, tx_done early, single-shot.
        capture(7999, 8000, 0);
        do_readout(60, 1, 1'b0);
        continuous = 1'b0;
        do_holdoff(1'b0, S_IDLE);
        check("idle_busy", busy, 0);

        // Crossing while IDLE is ignored.
        run = 1'b0;
        w0  = writes_seen;
        adc_sample = 14'd7000;
        step();
        adc_sample = 14'd8500;
        repeat (5) step();
        check("idle_state", state_dbg, S_IDLE);
        check("idle_no_write", writes_seen - w0, 0);

        // Continuous mode: tie of tx_done and timeout, crossing in HOLDOFF,
        // normal frame, then a timed-out frame.
        run        = 1'b1;
        continuous = 1'b1;
        capture(7000, 8200, 0);
        do_readout(TMO, 2, 1'b0);
        do_holdoff(1'b1, S_ARMED);
        capture(7500, 9000, 0);
        do_readout(30, 3, 1'b0);
        do_holdoff(1'b0, S_ARMED);
        capture(6000, 8001, 0);
        do_readout(0, 3, 1'b1);
        do_holdoff(1'b0, S_ARMED);
        check("timeout_sticky", timeout_err, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset in the middle of a capture at address 250.
        capture(7999, 8000, 251);
        w0 = writes_seen;
        repeat (10) step();
        check("post_reset_no_write", writes_seen - w0, 0);
        check("post_reset_frame_count", frame_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
